// File: rtl/btn_cond_pkg.sv
// btn_cond_pkg
// Shared constants, the auto-repeat state type and the priority helper
// used by the button conditioner.
package btn_cond_pkg;

    localparam int NUM_BTN  = 4;
    localparam int BTN_INC  = 0;
    localparam int BTN_ALT  = 1;
    localparam int BTN_NEXT = 2;
    localparam int BTN_CLR  = 3;

    typedef enum logic [1:0] {
        RPT_IDLE   = 2'd0,
        RPT_DELAY  = 2'd1,
        RPT_REPEAT = 2'd2
    } rpt_state_t;

    // Keep only the highest-numbered request; lower ones are dropped.
    function automatic logic [NUM_BTN-1:0] prio_pick(input logic [NUM_BTN-1:0] req);
        logic [NUM_BTN-1:0] grant;
        grant = '0;
        for (int i = 0; i < NUM_BTN; i++) begin
            if (req[i]) begin
                grant    = '0;
                grant[i] = 1'b1;
            end
        end
        return grant;
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// btn_debounce
// One-bit button conditioner: 2-flop synchronizer, stability counter,
// debounced level and a registered one-cycle rising-edge strobe.
// Ports:
//   clk   - system clock
//   rst   - synchronous active-high reset
//   raw   - asynchronous raw button input
//   lvl   - registered debounced level
//   rise  - registered one-cycle strobe, the cycle after lvl goes high
//   flip  - combinational: lvl toggles at the coming clock edge
module btn_debounce #(
    parameter int DB_CYC = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic lvl,
    output logic rise,
    output logic flip
);

    localparam int CW = $clog2(DB_CYC) + 1;

    logic          sync1;
    logic          sync2;
    logic [CW-1:0] cnt;

    // The DB_CYC-th consecutive differing sample flips the level.
    assign flip = (sync2 != lvl) && (cnt == CW'(DB_CYC - 1));

    // Synchronizer, stability counter and level/strobe registers.
    // The counter restarts whenever the synchronized input agrees with
    // the current level, so any shorter bounce is forgotten.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            cnt   <= '0;
            lvl   <= 1'b0;
            rise  <= 1'b0;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
            rise  <= flip & ~lvl;
            if (sync2 == lvl) begin
                cnt <= '0;
            end else if (flip) begin
                cnt <= '0;
                lvl <= ~lvl;
            end else begin
                cnt <= cnt + CW'(1);
            end
        end
    end

endmodule

// File: rtl/btn_cond.sv
// btn_cond
// Four-button conditioner: debounces every button, turns rising edges
// into single-cycle press pulses, adds auto-repeat on selected buttons
// and arbitrates so that at most one press pulse is issued per cycle.
// Ports:
//   clk   - system clock
//   rst   - synchronous active-high reset
//   btn_i - raw buttons: [0] increment, [1] alt-confirm, [2] next, [3] clear
//   num_o - registered one-hot press pulses (or zero)
//   lvl_o - registered debounced button levels
module btn_cond
    import btn_cond_pkg::*;
#(
    parameter int                 DB_CYC   = 4,
    parameter int                 RPT_DLY  = 8,
    parameter int                 RPT_PER  = 4,
    parameter logic [NUM_BTN-1:0] RPT_MASK = 4'b0001
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_BTN-1:0] btn_i,
    output logic [NUM_BTN-1:0] num_o,
    output logic [NUM_BTN-1:0] lvl_o
);

    localparam int RPT_MAX = (RPT_DLY > RPT_PER) ? RPT_DLY : RPT_PER;
    localparam int RCW     = $clog2(RPT_MAX) + 1;

    logic [NUM_BTN-1:0] lvl;
    logic [NUM_BTN-1:0] rise;
    logic [NUM_BTN-1:0] flip;
    logic [NUM_BTN-1:0] rpt_cand;

    rpt_state_t         state_q [NUM_BTN];
    rpt_state_t         state_d [NUM_BTN];
    logic [RCW-1:0]     cnt_q   [NUM_BTN];
    logic [RCW-1:0]     cnt_d   [NUM_BTN];

    for (genvar g = 0; g < NUM_BTN; g++) begin : g_db
        btn_debounce #(
            .DB_CYC (DB_CYC)
        ) u_db (
            .clk  (clk),
            .rst  (rst),
            .raw  (btn_i[g]),
            .lvl  (lvl[g]),
            .rise (rise[g]),
            .flip (flip[g])
        );
    end

    assign lvl_o = lvl;

    // Auto-repeat next-state logic. The counter is loaded on entry to a
    // state and counts down; reaching zero raises a repeat candidate and
    // reloads with the repeat period. A level that is low, or about to
    // fall at this edge, cancels the FSM and any candidate at once. A
    // clear press overrides everything, including a simultaneous press.
    always_comb begin
        rpt_cand = '0;
        for (int i = 0; i < NUM_BTN; i++) begin
            state_d[i] = state_q[i];
            cnt_d[i]   = cnt_q[i];
            if (RPT_MASK[i]) begin
                case (state_q[i])
                    RPT_IDLE: begin
                        if (rise[i]) begin
                            state_d[i] = RPT_DELAY;
                            cnt_d[i]   = RCW'(RPT_DLY - 1);
                        end
                    end
                    RPT_DELAY, RPT_REPEAT: begin
                        if (cnt_q[i] == '0) begin
                            rpt_cand[i] = 1'b1;
                            state_d[i]  = RPT_REPEAT;
                            cnt_d[i]    = RCW'(RPT_PER - 1);
                        end else begin
                            cnt_d[i] = cnt_q[i] - RCW'(1);
                        end
                    end
                    default: begin
                        state_d[i] = RPT_IDLE;
                        cnt_d[i]   = '0;
                    end
                endcase
                if (!lvl[i] || flip[i] || rise[BTN_CLR]) begin
                    state_d[i]  = RPT_IDLE;
                    cnt_d[i]    = '0;
                    rpt_cand[i] = 1'b0;
                end
            end
        end
    end

    // Repeat FSM registers and the arbitrated, registered press output.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_BTN; i++) begin
                state_q[i] <= RPT_IDLE;
                cnt_q[i]   <= '0;
            end
            num_o <= '0;
        end else begin
            for (int i = 0; i < NUM_BTN; i++) begin
                state_q[i] <= state_d[i];
                cnt_q[i]   <= cnt_d[i];
            end
            num_o <= prio_pick(rise | rpt_cand);
        end
    end

endmodule

// File: tb/tb_btn_cond.sv
// tb_btn_cond
// Self-checking bench for btn_cond with default parameters. A
// window/age based reference model predicts num_o and lvl_o every cycle;
// directed sequences add hand-computed checkpoints.
module tb_btn_cond;

    localparam int DB_CYC  = 4;
    localparam int RPT_DLY = 8;
    localparam int RPT_PER = 4;

    logic       clk;
    logic       rst;
    logic [3:0] btn_i;
    logic [3:0] num_o;
    logic [3:0] lvl_o;

    int checks = 0;
    int errors = 0;

    btn_cond #(
        .DB_CYC   (DB_CYC),
        .RPT_DLY  (RPT_DLY),
        .RPT_PER  (RPT_PER),
        .RPT_MASK (4'b0001)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .btn_i (btn_i),
        .num_o (num_o),
        .lvl_o (lvl_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model state
    logic [3:0] hist [0:DB_CYC];
    logic [3:0] m_lvl;
    logic [3:0] m_pend;
    logic [3:0] m_num;
    logic [3:0] m_tog;
    logic       m_active;
    logic       m_rpt;
    logic       m_fall0;
    int         m_age;
    int         m_a;
    bit         model_valid = 1'b0;

    function automatic logic [3:0] highest(input logic [3:0] req);
        if (req[3])      return 4'b1000;
        else if (req[2]) return 4'b0100;
        else if (req[1]) return 4'b0010;
        else if (req[0]) return 4'b0001;
        else             return 4'b0000;
    endfunction

    // Model: a level flips once the last DB_CYC synchronized samples (raw
    // samples 2..DB_CYC+1 edges old) all disagree with it; a press is
    // issued one edge after the flip; repeats fall at RPT_DLY and every
    // RPT_PER edges after the press edge while the button stays down.
    always @(posedge clk) begin
        model_valid = 1'b1;
        if (rst) begin
            for (int k = 0; k <= DB_CYC; k++) hist[k] = 4'b0000;
            m_lvl    = 4'b0000;
            m_pend   = 4'b0000;
            m_num    = 4'b0000;
            m_active = 1'b0;
            m_age    = 0;
        end else begin
            for (int i = 0; i < 4; i++) begin
                m_tog[i] = 1'b1;
                for (int k = 1; k <= DB_CYC; k++)
                    if (hist[k][i] == m_lvl[i]) m_tog[i] = 1'b0;
            end
            m_fall0 = m_tog[0] && m_lvl[0];
            m_a     = m_age + 1;
            m_rpt   = m_active && m_lvl[0] && !m_fall0 &&
                      (m_a == RPT_DLY ||
                       (m_a > RPT_DLY && ((m_a - RPT_DLY) % RPT_PER) == 0));
            m_num   = highest(m_pend | {3'b000, m_rpt});
            m_age   = m_a;
            if (m_pend[0]) begin
                m_active = 1'b1;
                m_age    = 0;
            end
            if (m_pend[3] || m_fall0) m_active = 1'b0;
            m_pend = m_tog & ~m_lvl;
            m_lvl  = m_lvl ^ m_tog;
            for (int k = DB_CYC; k >= 1; k--) hist[k] = hist[k-1];
            hist[0] = btn_i;
        end
    end

    task automatic check_output(input string name, input logic [3:0] act,
                                input logic [3:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s actual=%b required=%b", name, act, exp);
        end
    endtask

    task automatic check_count(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("[TB] FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    task automatic apply_stimulus(input logic [3:0] b);
        btn_i = b;
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Cycle-by-cycle comparison against the model
    always @(negedge clk) begin
        if (model_valid) begin
            check_output("model_num", num_o, m_num);
            check_output("model_lvl", lvl_o, m_lvl);
        end
    end

    initial begin
        int pulses;
        rst   = 1'b1;
        btn_i = 4'b0000;
        step(3);
        check_output("reset_num", num_o, 4'b0000);
        check_output("reset_lvl", lvl_o, 4'b0000);
        rst = 1'b0;
        step(4);

        $display("[TB] single short press on increment");
        apply_stimulus(4'b0001);
        step(5);
        check_output("a_lvl_pre", lvl_o, 4'b0000);
        apply_stimulus(4'b0000);
        step(1);
        check_output("a_lvl", lvl_o, 4'b0001);
        check_output("a_num_pre", num_o, 4'b0000);
        step(1);
        check_output("a_num", num_o, 4'b0001);
        step(1);
        check_output("a_num_post", num_o, 4'b0000);
        step(12);
        check_output("a_lvl_fall", lvl_o, 4'b0000);

        $display("[TB] glitch shorter than debounce window");
        apply_stimulus(4'b0010);
        step(3);
        apply_stimulus(4'b0000);
        step(8);
        check_output("b_lvl", lvl_o, 4'b0000);
        check_output("b_num", num_o, 4'b0000);

        $display("[TB] bouncing next button then steady");
        for (int k = 0; k < 12; k++) begin
            apply_stimulus(((k / 2) % 2 == 0) ? 4'b0100 : 4'b0000);
            step(1);
        end
        apply_stimulus(4'b0100);
        step(6);
        check_output("c_num_pre", num_o, 4'b0000);
        check_output("c_lvl", lvl_o, 4'b0100);
        step(1);
        check_output("c_num", num_o, 4'b0100);
        step(1);
        check_output("c_num_post", num_o, 4'b0000);
        apply_stimulus(4'b0000);
        step(12);
        check_output("c_lvl_fall", lvl_o, 4'b0000);

        $display("[TB] clear and increment together");
        apply_stimulus(4'b1001);
        step(6);
        check_output("d_lvl", lvl_o, 4'b1001);
        check_output("d_num_pre", num_o, 4'b0000);
        step(1);
        check_output("d_num", num_o, 4'b1000);
        step(8);
        check_output("d_no_repeat", num_o, 4'b0000);
        apply_stimulus(4'b0000);
        step(12);
        check_output("d_lvl_fall", lvl_o, 4'b0000);

        $display("[TB] held increment with auto-repeat");
        apply_stimulus(4'b0001);
        pulses = 0;
        for (int j = 0; j < 52; j++) begin
            step(1);
            if (num_o == 4'b0001) pulses++;
            if (j == 13) check_output("e_pre_rpt", num_o, 4'b0000);
            if (j == 14) check_output("e_first_rpt", num_o, 4'b0001);
            if (j == 18) check_output("e_second_rpt", num_o, 4'b0001);
            if (j == 39) apply_stimulus(4'b0000);
            if (j == 42) check_output("e_last_rpt", num_o, 4'b0001);
            if (j == 45) check_output("e_lvl_fall", lvl_o, 4'b0000);
            if (j == 46) check_output("e_none_after", num_o, 4'b0000);
        end
        check_count("e_pulse_count", pulses, 9);

        $display("[TB] reset while held");
        apply_stimulus(4'b0001);
        for (int j = 0; j < 20; j++) begin
            step(1);
            if (j == 9) rst = 1'b1;
            if (j == 10) begin
                rst = 1'b0;
                check_output("f_num_rst", num_o, 4'b0000);
                check_output("f_lvl_rst", lvl_o, 4'b0000);
            end
            if (j == 16) check_output("f_num_pre", num_o, 4'b0000);
            if (j == 17) check_output("f_num", num_o, 4'b0001);
        end
        apply_stimulus(4'b0000);
        step(12);

        $display("[TB] reset mid-debounce");
        apply_stimulus(4'b0100);
        step(3);
        rst = 1'b1;
        apply_stimulus(4'b0000);
        step(1);
        rst = 1'b0;
        step(10);
        check_output("g_lvl", lvl_o, 4'b0000);
        check_output("g_num", num_o, 4'b0000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/btn_cond.md
BTN_COND -- requirements
Module: btn_cond

Interface
REQ-001 Parameter DB_CYC, default 4: consecutive stable samples needed to accept a new button level.
REQ-002 Parameter RPT_DLY, default 8: cycles from a press pulse to the first auto-repeat pulse.
REQ-003 Parameter RPT_PER, default 4: cycles between later auto-repeat pulses.
REQ-004 Parameter RPT_MASK, default 4'b0001: buttons with auto-repeat enabled (increment button only).
REQ-005 clk  input  1  single system clock; all state updates on its rising edge.
REQ-006 rst  input  1  synchronous, active-high reset.
REQ-007 btn_i  input  4  raw asynchronous push-buttons: [0] increment, [1] alt-confirm, [2] next/confirm, [3] clear.
REQ-008 num_o  output  4  registered single-cycle press pulses, at most one bit high; drives the calculator num_i port directly.
REQ-009 lvl_o  output  4  registered debounced button levels.

Function
REQ-010 Each btn_i bit SHALL pass through a 2-flop synchronizer before any other logic.
REQ-011 Per bit, counter SHALL clear whenever synchronized value equals lvl_o bit, and increment otherwise.
REQ-012 When the counter has seen DB_CYC consecutive differing samples, lvl_o bit SHALL toggle and the counter SHALL clear.
REQ-013 Any bounce shorter than DB_CYC cycles SHALL leave lvl_o and num_o unchanged.
REQ-014 A rising edge on lvl_o[i] SHALL produce exactly one cycle of num_o[i]=1; falling edges produce no pulse.
REQ-015 Latency: raw high first sampled at edge N and held -> num_o bit high for the single cycle after edge N+DB_CYC+2.
REQ-016 Simultaneous pulse candidates (edge or repeat) SHALL be resolved by priority [3]>[2]>[1]>[0]; losers are dropped, not queued.
REQ-017 lvl_o SHALL be unaffected by priority arbitration.
REQ-018 Auto-repeat per RPT_MASK bit: states IDLE -> DELAY on press pulse; DELAY -> REPEAT after RPT_DLY cycles with pulse; REPEAT pulses every RPT_PER cycles.
REQ-019 Auto-repeat SHALL return to IDLE in the same cycle lvl_o bit goes low; no repeat pulse in that cycle or after.
REQ-020 Repeat counters SHALL saturate-free wrap only via reload; width = clog2(max(RPT_DLY,RPT_PER))+1.
REQ-021 A press on bit 3 (clear) SHALL also force every auto-repeat FSM to IDLE.
REQ-022 num_o SHALL be 4'b0000 in every cycle without a qualifying event.

Reset
REQ-023 rst SHALL clear synchronizers, counters, lvl_o, num_o to 0 and all repeat FSMs to IDLE at the next edge.
REQ-024 A button held through rst release SHALL be treated as a new press: pulse after full REQ-015 latency counted from the first post-reset edge.
REQ-025 rst asserted mid-debounce or mid-repeat SHALL discard the pending event with no pulse.

Structure
REQ-026 Package btn_cond_pkg SHALL hold NUM_BTN=4, index constants BTN_INC=0, BTN_ALT=1, BTN_NEXT=2, BTN_CLR=3, and the repeat-FSM state enum.
REQ-027 Sub-module btn_debounce (one bit: synchronizer, counter, level, rise strobe) SHALL be instantiated NUM_BTN times.
REQ-028 Priority arbiter and repeat FSMs SHALL live in btn_cond top; outputs registered.

Verification (defaults DB_CYC=4, RPT_DLY=8, RPT_PER=4)
REQ-029 btn_i[0] high from edge N for 5 cycles -> num_o=0001 only in cycle after edge N+6; lvl_o[0] high from N+5.
REQ-030 btn_i[2] toggling every 2 cycles for 12 cycles then steady high -> no pulse during bouncing; one 0100 pulse 6 cycles after steady sampling.
REQ-031 btn_i=1001 rising at same edge -> num_o=1000 once; no 0001 pulse; lvl_o=1001.
REQ-032 btn_i[0] held 40 cycles from edge N -> pulses at N+6, N+14, then every 4 cycles until lvl_o[0] falls; none afterwards.
REQ-033 btn_i[0] held, rst pulsed 1 cycle at N+10 -> num_o=0, lvl_o=0 after edge; new 0001 pulse 6 cycles after rst release.
REQ-034 btn_i[1] high 3 cycles then low -> num_o stays 0000, lvl_o[1] stays 0.
